// File: rtl/odom_quad_counter_if.sv
// SPI-side bundle of the odometry counter.
// Carries chip select and command in, snapshot word and its strobe out.
interface odom_quad_counter_if;
    logic        spi_cs;
    logic [31:0] cmd;
    logic [31:0] data_out;
    logic        snap_valid;

    modport master (
        output spi_cs,
        output cmd,
        input  data_out,
        input  snap_valid
    );

    modport slave (
        input  spi_cs,
        input  cmd,
        output data_out,
        output snap_valid
    );
endinterface

// File: rtl/odom_quad_counter.sv
// Dual quadrature decoder feeding the Pi SPI word; CS-edge snapshot and clear.
// Optional macro ODOM_GLITCH_FILTER_EN adds a per-line stability filter.
module odom_quad_counter #(
    parameter int         CNT_W    = 16,
    parameter int         FILT_LEN = 4,
    parameter bit         INV_L    = 1'b0,
    parameter bit         INV_R    = 1'b1,
    parameter logic [7:0] CLR_KEY  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enc_a_l,
    input  logic              enc_b_l,
    input  logic              enc_a_r,
    input  logic              enc_b_r,
    odom_quad_counter_if.slave spi,
    output logic              err_l,
    output logic              err_r
);

    logic [4:0] sync1;
    logic [4:0] sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {enc_a_l, enc_b_l, enc_a_r, enc_b_r, spi.spi_cs};
            sync2 <= sync1;
        end
    end

    logic       cs_s;
    logic [3:0] enc;

    assign cs_s = sync2[0];

`ifdef ODOM_GLITCH_FILTER_EN
    localparam int PRIME = FILT_LEN + 3;

    logic [3:0] filt;
    logic [3:0] run [4];

    // A line flips only after disagreeing with its filtered value FILT_LEN times in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= '0;
            for (int i = 0; i < 4; i++) run[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i+1] == filt[i]) begin
                    run[i] <= '0;
                end else if (run[i] == 4'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i+1];
                    run[i]  <= '0;
                end else begin
                    run[i] <= run[i] + 4'd1;
                end
            end
        end
    end

    assign enc = filt;
`else
    localparam int PRIME = 3;

    assign enc = sync2[4:1];
`endif

    localparam logic [4:0] PRIME_C = 5'(PRIME);

    logic [CNT_W-1:0] one_c;
    assign one_c = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    logic [4:0]       prime_cnt;
    logic             priming;
    logic             cs_d;
    logic [1:0]       cur_l, cur_r;
    logic [1:0]       prev_l, prev_r;
    logic [1:0]       d_l, d_r;
    logic [CNT_W-1:0] cnt_l, cnt_r;
    logic [CNT_W-1:0] step_l, step_r;
    logic             ill_l, ill_r;
    logic             rise, fall;
    logic             key_ok, do_clr, err_clr;
    logic             unused_bits;

    assign cur_l   = enc[3:2];
    assign cur_r   = enc[1:0];
    assign priming = prime_cnt != PRIME_C;

    assign unused_bits = ^{spi.cmd[23:2], 4'(FILT_LEN)};

    // Position delta mod 4: 1 forward, 3 reverse, 2 means both lines moved.
    always_comb begin
        d_l    = gray2bin(cur_l) - gray2bin(prev_l);
        d_r    = gray2bin(cur_r) - gray2bin(prev_r);
        step_l = '0;
        step_r = '0;
        unique case (1'b1)
            d_l == 2'd1: step_l = INV_L ? '1 : one_c;
            d_l == 2'd3: step_l = INV_L ? one_c : '1;
            default:     step_l = '0;
        endcase
        unique case (1'b1)
            d_r == 2'd1: step_r = INV_R ? '1 : one_c;
            d_r == 2'd3: step_r = INV_R ? one_c : '1;
            default:     step_r = '0;
        endcase
        ill_l = d_l == 2'd2;
        ill_r = d_r == 2'd2;
    end

    always_comb begin
        rise    = !priming && cs_s && !cs_d;
        fall    = !priming && !cs_s && cs_d;
        key_ok  = spi.cmd[31:24] == CLR_KEY;
        do_clr  = rise && key_ok && spi.cmd[0];
        err_clr = rise && key_ok && spi.cmd[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt      <= '0;
            cs_d           <= 1'b0;
            prev_l         <= '0;
            prev_r         <= '0;
            cnt_l          <= '0;
            cnt_r          <= '0;
            err_l          <= 1'b0;
            err_r          <= 1'b0;
            spi.data_out   <= '0;
            spi.snap_valid <= 1'b0;
        end else begin
            cs_d           <= cs_s;
            prev_l         <= cur_l;
            prev_r         <= cur_r;
            spi.snap_valid <= fall;
            if (priming) prime_cnt <= prime_cnt + 5'd1;
            if (fall) spi.data_out <= {cnt_l, cnt_r};
            if (do_clr) begin
                cnt_l <= '0;
                cnt_r <= '0;
                err_l <= 1'b0;
                err_r <= 1'b0;
            end else if (!priming) begin
                cnt_l <= cnt_l + step_l;
                cnt_r <= cnt_r + step_r;
                if (err_clr) begin
                    err_l <= 1'b0;
                    err_r <= 1'b0;
                end else begin
                    if (ill_l) err_l <= 1'b1;
                    if (ill_r) err_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_odom_quad_counter.sv
// Bench for odom_quad_counter: position-table model checked every cycle
// plus directed snapshot checks with hand-computed words.
module tb_odom_quad_counter;
    localparam int FILT_LEN = 4;
`ifdef ODOM_GLITCH_FILTER_EN
    localparam int PRIME = FILT_LEN + 3;
    localparam int LAT   = 6 + FILT_LEN;
`else
    localparam int PRIME = 3;
    localparam int LAT   = 6;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] enc_l, enc_r;
    logic       err_l, err_r;

    always #5 clk = ~clk;

    odom_quad_counter_if spi ();

    odom_quad_counter #(
        .CNT_W(16), .FILT_LEN(FILT_LEN), .INV_L(1'b0),
        .INV_R(1'b1), .CLR_KEY(8'hA5)
    ) dut (
        .clk(clk), .reset(reset),
        .enc_a_l(enc_l[1]), .enc_b_l(enc_l[0]),
        .enc_a_r(enc_r[1]), .enc_b_r(enc_r[0]),
        .spi(spi), .err_l(err_l), .err_r(err_r)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Quadrature position of each {A,B} state, and the state at each position.
    int         pos_of [4] = '{0, 1, 3, 2};
    logic [1:0] seq    [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    typedef struct packed {
        logic        rst;
        logic        cs;
        logic [31:0] cmd;
        logic [1:0]  el;
        logic [1:0]  er;
    } samp_t;

    samp_t       h [4];
    logic [15:0] m_l = '0, m_r = '0;
    logic        m_el = 1'b0, m_er = 1'b0, m_sv = 1'b0;
    logic [31:0] m_dout = '0;
    int          since = 0;
`ifdef ODOM_GLITCH_FILTER_EN
    logic [3:0]  mf = '0, mf_prev = '0;
    int          mrun [4] = '{0, 0, 0, 0};
`endif

    initial for (int i = 0; i < 4; i++) h[i] = '0;

    function automatic int delta(input logic [1:0] cur, input logic [1:0] prev);
        return (pos_of[cur] - pos_of[prev] + 4) % 4;
    endfunction

    always @(posedge clk) begin
        logic [1:0] cl, cr, pl, pr;
        logic       fall, rise, key;
        logic [3:0] raw;
        int         dl, dr;
        #1;
        for (int i = 3; i > 0; i--) h[i] = h[i-1];
        h[0] = {reset, spi.spi_cs, spi.cmd, enc_l, enc_r};
        if (h[0].rst) begin
            m_l = '0; m_r = '0; m_el = 1'b0; m_er = 1'b0;
            m_dout = '0; m_sv = 1'b0; since = 0;
`ifdef ODOM_GLITCH_FILTER_EN
            mf = '0; mf_prev = '0;
            for (int i = 0; i < 4; i++) mrun[i] = 0;
`endif
        end else begin
            m_sv = 1'b0;
            since++;
`ifdef ODOM_GLITCH_FILTER_EN
            cl = mf[3:2]; cr = mf[1:0];
            pl = mf_prev[3:2]; pr = mf_prev[1:0];
            mf_prev = mf;
            raw = {h[2].el, h[2].er};
            for (int i = 0; i < 4; i++) begin
                if (raw[i] == mf[i]) mrun[i] = 0;
                else begin
                    mrun[i]++;
                    if (mrun[i] == FILT_LEN) begin
                        mf[i] = raw[i];
                        mrun[i] = 0;
                    end
                end
            end
`else
            raw = '0;
            cl = h[2].el; cr = h[2].er;
            pl = h[3].el; pr = h[3].er;
`endif
            if (since > PRIME) begin
                fall = h[3].cs && !h[2].cs;
                rise = !h[3].cs && h[2].cs;
                key  = rise && (h[0].cmd[31:24] == 8'hA5);
                if (fall) begin
                    m_dout = {m_l, m_r};
                    m_sv   = 1'b1;
                end
                if (key && h[0].cmd[0]) begin
                    m_l = '0; m_r = '0; m_el = 1'b0; m_er = 1'b0;
                end else begin
                    dl = delta(cl, pl);
                    dr = delta(cr, pr);
                    if (dl == 1) m_l = m_l + 16'd1;
                    else if (dl == 3) m_l = m_l - 16'd1;
                    // right wheel is mirror-mounted
                    if (dr == 1) m_r = m_r - 16'd1;
                    else if (dr == 3) m_r = m_r + 16'd1;
                    if (key && h[0].cmd[1]) begin
                        m_el = 1'b0; m_er = 1'b0;
                    end else begin
                        if (dl == 2) m_el = 1'b1;
                        if (dr == 2) m_er = 1'b1;
                    end
                end
            end
        end
        check("data_out", spi.data_out, m_dout);
        check("snap_valid", {31'd0, spi.snap_valid}, {31'd0, m_sv});
        check("err_l", {31'd0, err_l}, {31'd0, m_el});
        check("err_r", {31'd0, err_r}, {31'd0, m_er});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic move_l(input bit fwd);
        enc_l = seq[fwd ? (pos_of[enc_l] + 1) % 4 : (pos_of[enc_l] + 3) % 4];
    endtask

    task automatic move_r(input bit fwd);
        enc_r = seq[fwd ? (pos_of[enc_r] + 1) % 4 : (pos_of[enc_r] + 3) % 4];
    endtask

    // Full CS low/high transaction; returns the snapshot word.
    task automatic snap(output logic [31:0] d);
        spi.spi_cs = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("snap_pulse", {31'd0, spi.snap_valid}, 32'd1);
        d = spi.data_out;
        @(posedge clk);
        #2;
        check("snap_single", {31'd0, spi.snap_valid}, 32'd0);
        @(negedge clk);
        spi.spi_cs = 1'b1;
        cyc(5);
    endtask

    logic [31:0] d;
    logic [15:0] base_l;

    initial begin
        reset = 1'b1;
        enc_l = 2'b00;
        enc_r = 2'b00;
        spi.spi_cs = 1'b1;
        spi.cmd = '0;
        cyc(4);
        reset = 1'b0;
        cyc(10);
        check("rst_dout", spi.data_out, 32'd0);
        check("rst_err_l", {31'd0, err_l}, 32'd0);
        check("rst_err_r", {31'd0, err_r}, 32'd0);

        for (int i = 0; i < 32; i++) begin
            move_l(1'b1);
            cyc(4);
        end
        cyc(LAT);
        snap(d);
        check("fwd32_l", d, 32'h0020_0000);

        for (int i = 0; i < 5; i++) begin
            move_r(1'b0);
            cyc(4);
        end
        cyc(LAT);
        snap(d);
        check("rev5_r", {16'd0, d[15:0]}, 32'h0000_0005);

        spi.cmd = 32'hA500_0001;
        snap(d);
        spi.cmd = '0;
        check("pre_clr", d, 32'h0020_0005);
        snap(d);
        check("clr_all", d, 32'h0000_0000);

        move_l(1'b0);
        cyc(LAT);
        snap(d);
        check("wrap_neg", d, 32'hFFFF_0000);
        move_l(1'b1);
        cyc(LAT);

`ifdef ODOM_GLITCH_FILTER_EN
        base_l = 16'h0000;
`else
        for (int i = 0; i < 32767; i++) begin
            move_l(1'b1);
            cyc(1);
        end
        cyc(LAT);
        snap(d);
        check("max_pos", d, 32'h7FFF_0000);
        move_l(1'b1);
        cyc(LAT);
        snap(d);
        check("wrap_pos", d, 32'h8000_0000);
        base_l = 16'h8000;
`endif

        enc_l = ~enc_l;
        cyc(LAT);
        check("jump_err", {31'd0, err_l}, 32'd1);
        snap(d);
        check("jump_keep", d, {base_l, 16'h0000});
        spi.cmd = 32'hA500_0002;
        snap(d);
        spi.cmd = '0;
        check("errclr_err", {31'd0, err_l}, 32'd0);
        snap(d);
        check("errclr_keep", d, {base_l, 16'h0000});

        spi.cmd = 32'hA500_0001;
        spi.spi_cs = 1'b0;
        cyc(6);
`ifdef ODOM_GLITCH_FILTER_EN
        move_l(1'b1);
        cyc(FILT_LEN);
`else
        move_l(1'b1);
`endif
        spi.spi_cs = 1'b1;
        cyc(LAT);
        spi.cmd = '0;
        snap(d);
        check("clr_coinc", d, 32'h0000_0000);

        move_l(1'b1);
        cyc(LAT);
        spi.cmd = 32'h1200_0001;
        snap(d);
        spi.cmd = '0;
        snap(d);
        check("bad_key", d, 32'h0001_0000);

`ifdef ODOM_GLITCH_FILTER_EN
        enc_l[1] = 1'b1;
        cyc(2);
        enc_l[1] = 1'b0;
        cyc(LAT + 4);
        snap(d);
        check("glitch_rej", d, 32'h0001_0000);
        enc_l = 2'b01;
        cyc(6 + LAT);
        snap(d);
        check("stable_acc", d, 32'h0002_0000);
`endif

        enc_l = 2'b00;
        enc_r = 2'b00;
        cyc(LAT);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(LAT + 4);
        check("rst_mid_dout", spi.data_out, 32'd0);
        snap(d);
        check("rst_mid_cnt", d, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
